// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Control FSM for the matrix multiplier.  Once both operand memories report
// loaded, computes C = A x B one element at a time.  It reads A[i][k] and
// B[k][j] through the synchronous read ports and sums the products in a single
// unsigned accumulator.  Each finished element is written to result memory C,
// and done is raised for the UART TX stage once the last element is written.
//
// Build option:
//   MATMUL_SATURATE_EN  defined   -> C elements saturate at 2^DW-1
//                       undefined -> C elements are acc[DW-1:0] (wrap)
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   start                    request one multiply (seen in IDLE only)
//   clear                    leave DONE, return to IDLE
//   a_ready, b_ready         operand memories fully loaded (levels)
//   a_rd_en/addr/data        memory A read port, data valid 1 cycle after en
//   b_rd_en/addr/data        memory B read port, data valid 1 cycle after en
//   c_wr_en/addr/data        memory C write port, one strobe per element
//   busy                     high in WAIT_LOAD, READ, MAC, WRITE
//   done                     high in DONE only
//
// All outputs are registered: each output register is loaded from the value
// the output must have in the *next* state, so outputs line up with state_q.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start
// WAIT_LOAD | waiting for a_ready && b_ready
// READ      | read strobes out for A[i][k], B[k][j]
// MAC       | read data valid; acc += a*b
// WRITE     | C[i][j] written; advance j/i
// DONE      | result complete; waiting for clear
// -----------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int M    = 2,
    parameter int K    = 2,
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int ACCW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clear,
    input  logic          a_ready,
    input  logic          b_ready,
    output logic          a_rd_en,
    output logic [AW-1:0] a_rd_addr,
    input  logic [DW-1:0] a_rd_data,
    output logic          b_rd_en,
    output logic [AW-1:0] b_rd_addr,
    input  logic [DW-1:0] b_rd_data,
    output logic          c_wr_en,
    output logic [AW-1:0] c_wr_addr,
    output logic [DW-1:0] c_wr_data,
    output logic          busy,
    output logic          done
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [AW-1:0] K_AW   = AW'(K);
    localparam logic [AW-1:0] N_AW   = AW'(N);
    localparam logic [ACCW-1:0] ELEM_MAX = ACCW'((2 ** DW) - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOAD = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_MAC       = 3'd3;
    localparam logic [2:0] S_WRITE     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;

    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   a_addr_q, a_addr_d;
    logic [AW-1:0]   b_addr_q, b_addr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [ACCW-1:0] prod;

    function automatic logic [DW-1:0] fmt_elem(input logic [ACCW-1:0] acc);
`ifdef MATMUL_SATURATE_EN
        fmt_elem = (acc > ELEM_MAX) ? {DW{1'b1}} : acc[DW-1:0];
`else
        fmt_elem = acc[DW-1:0];
`endif
    endfunction

    // Full 2*DW product, zero-extended; ACCW is sized so K of these cannot overflow.
    assign prod = ACCW'(a_rd_data) * ACCW'(b_rd_data);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_LOAD;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_WAIT_LOAD: begin
                if (a_ready && b_ready) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + prod;
                if (k_q == K_LAST) begin
                    // Element finished: stage the write so it appears in WRITE.
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(i_q) * N_AW + AW'(j_q);
                    wr_data_d = fmt_elem(acc_d);
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                acc_d = '0;
                k_d   = '0;
                if ((i_q == I_LAST) && (j_q == J_LAST)) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_DONE;
                end else begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read strobe/addresses are driven from the counters that READ will see.
        rd_en_d  = (state_d == S_READ);
        a_addr_d = rd_en_d ? (AW'(i_d) * K_AW + AW'(k_d)) : a_addr_q;
        b_addr_d = rd_en_d ? (AW'(k_d) * N_AW + AW'(j_d)) : b_addr_q;
        busy_d   = (state_d == S_WAIT_LOAD) || (state_d == S_READ) ||
                   (state_d == S_MAC) || (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            rd_en_q   <= rd_en_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign a_rd_addr = a_addr_q;
    assign b_rd_addr = b_addr_q;
    assign c_wr_en   = wr_en_q;
    assign c_wr_addr = wr_addr_q;
    assign c_wr_data = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
